// File: rtl/boa_pkg.sv
// Boa32 shared definitions: MEM stage FSM states, trap causes,
// memory opcodes and load/store funct3 encodings.
package boa_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HELD
    } mem_state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/boa_mem_align.sv
// Boa32 MEM byte-lane steering: store enables/replication,
// load extraction with sign/zero extension, alignment checks.
module boa_mem_align
    import boa_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic        store,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  we,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] lane;

    assign lane = rdata >> {addr, 3'b000};

    assign misaligned = (funct3[1:0] == 2'b01 && addr[0])
                      || (funct3[1:0] == 2'b10 && addr != 2'b00);

    always_comb begin
        we      = 4'b0000;
        wdata   = rs2;
        ld_data = rdata;
        illegal = 1'b0;
        if (store) begin
            unique case (funct3)
                F3_B: begin
                    we    = 4'b0001 << addr;
                    wdata = {4{rs2[7:0]}};
                end
                F3_H: begin
                    we    = 4'b0011 << addr;
                    wdata = {2{rs2[15:0]}};
                end
                F3_W:    we = 4'b1111;
                default: illegal = 1'b1;
            endcase
        end else begin
            unique case (funct3)
                F3_B:    ld_data = {{24{lane[7]}}, lane[7:0]};
                F3_H:    ld_data = {{16{lane[15]}}, lane[15:0]};
                F3_W:    ld_data = rdata;
                F3_BU:   ld_data = {24'd0, lane[7:0]};
                F3_HU:   ld_data = {16'd0, lane[15:0]};
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/boa_stage_mem.sv
// Boa32 MEM pipeline stage: data bus access, traps, MEM/WB register.
// Optional bus timeout enabled by defining BOA_MEM_TIMEOUT_EN.
module boa_stage_mem
    import boa_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        d_valid,
    input  logic [31:1] d_pc,
    input  logic [31:0] d_insn,
    input  logic        d_use_rd,
    input  logic [31:0] d_rs1_val,
    input  logic [31:0] d_rs2_val,
    input  logic        d_trap,
    input  logic [3:0]  d_cause,
    output logic        q_valid,
    output logic [31:1] q_pc,
    output logic [31:0] q_insn,
    output logic        q_use_rd,
    output logic [31:0] q_rs1_val,
    output logic        q_trap,
    output logic [3:0]  q_cause,
    output logic        bus_re,
    output logic [3:0]  bus_we,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    input  logic        fw_stall_mem,
    output logic        fw_stall_req,
    output logic        fw_rd,
    output logic [31:0] fw_out
);

    mem_state_e  state, nxt;
    logic [31:0] p_addr, p_rs2, hold_q;
    logic [2:0]  p_f3;
    logic        p_st, p_drop;

    logic        d_ld, d_st, mem_op, in_wait;
    logic [31:0] src_addr, src_rs2;
    logic [2:0]  src_f3;
    logic        src_st;
    logic [3:0]  we;
    logic [31:0] wdata, ld_data;
    logic        misal, illegal;
    logic        idle_req, req, done, drop_now, timeout, upd;
    logic [31:0] n_res;
    logic        n_trap;
    logic [3:0]  n_cause;

    assign d_ld    = d_insn[6:0] == OP_LOAD;
    assign d_st    = d_insn[6:0] == OP_STORE;
    assign mem_op  = d_valid && !d_trap && (d_ld || d_st);
    assign in_wait = state == S_WAIT;

    // Outstanding requests replay from latched copies so the bus sees no change
    assign src_addr = in_wait ? p_addr : d_rs1_val;
    assign src_rs2  = in_wait ? p_rs2  : d_rs2_val;
    assign src_f3   = in_wait ? p_f3   : d_insn[14:12];
    assign src_st   = in_wait ? p_st   : d_st;

    boa_mem_align u_align (
        .funct3     (src_f3),
        .addr       (src_addr[1:0]),
        .store      (src_st),
        .rs2        (src_rs2),
        .rdata      (bus_rdata),
        .we         (we),
        .wdata      (wdata),
        .ld_data    (ld_data),
        .misaligned (misal),
        .illegal    (illegal)
    );

    assign idle_req = rst && state == S_IDLE && mem_op
                    && !misal && !illegal;
    assign req      = idle_req || in_wait;
    assign done     = req && bus_ready;
    assign drop_now = in_wait && p_drop;

    assign bus_re       = req && !src_st;
    assign bus_we       = (req && src_st) ? we : 4'b0000;
    assign bus_addr     = src_addr[31:2];
    assign bus_wdata    = wdata;
    assign fw_stall_req = req && !bus_ready && !timeout;

`ifdef BOA_MEM_TIMEOUT_EN
    localparam int CB = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = (CB > 8) ? CB : 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] to_cnt;

    assign timeout = in_wait && !bus_ready && !fw_stall_mem
                   && to_cnt == TO_LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= '0;
        else if (bus_ready || timeout)
            to_cnt <= '0;
        else if (in_wait && to_cnt != TO_LAST)
            to_cnt <= to_cnt + 1'b1;
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: begin
                if (idle_req && !bus_ready)
                    nxt = S_WAIT;
                else if (idle_req && fw_stall_mem && !clear)
                    nxt = S_HELD;
            end
            S_WAIT: begin
                if (bus_ready)
                    nxt = (fw_stall_mem && !p_drop && !clear)
                        ? S_HELD : S_IDLE;
                else if (timeout)
                    nxt = S_IDLE;
            end
            S_HELD: begin
                if (clear || !fw_stall_mem)
                    nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        n_res   = d_rs1_val;
        n_trap  = d_trap;
        n_cause = d_cause;
        if (mem_op) begin
            if (illegal) begin
                n_trap  = 1'b1;
                n_cause = CAUSE_ILLEGAL;
            end else if (misal) begin
                n_trap  = 1'b1;
                n_cause = d_ld ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
            end else if (timeout) begin
                n_trap  = 1'b1;
                n_cause = d_ld ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
            end else if (d_ld) begin
                n_res = (state == S_HELD) ? hold_q : ld_data;
            end
        end
    end

    always_comb begin
        fw_out = d_rs1_val;
        fw_rd  = 1'b0;
        if (state == S_HELD) begin
            fw_out = hold_q;
            fw_rd  = d_ld && d_use_rd;
        end else if (!(d_ld || d_st)) begin
            fw_rd = d_valid && d_use_rd;
        end else if (d_ld) begin
            fw_out = ld_data;
            fw_rd  = done && d_use_rd && !drop_now && !clear;
        end
    end

    assign upd = !fw_stall_mem && !drop_now
               && (state == S_HELD || !req || bus_ready || timeout);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            p_addr <= '0;
            p_rs2  <= '0;
            p_f3   <= '0;
            p_st   <= 1'b0;
            p_drop <= 1'b0;
            hold_q <= '0;
        end else begin
            state <= nxt;
            if (idle_req && !bus_ready) begin
                p_addr <= d_rs1_val;
                p_rs2  <= d_rs2_val;
                p_f3   <= d_insn[14:12];
                p_st   <= d_st;
                p_drop <= clear;
            end else if (in_wait) begin
                p_drop <= p_drop || clear;
            end
            if (done && fw_stall_mem)
                hold_q <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid   <= 1'b0;
            q_pc      <= '0;
            q_insn    <= '0;
            q_use_rd  <= 1'b0;
            q_rs1_val <= '0;
            q_trap    <= 1'b0;
            q_cause   <= '0;
        end else if (clear) begin
            q_valid <= 1'b0;
            q_trap  <= 1'b0;
        end else if (upd) begin
            q_valid   <= d_valid;
            q_pc      <= d_pc;
            q_insn    <= d_insn;
            q_use_rd  <= d_use_rd;
            q_rs1_val <= n_res;
            q_trap    <= n_trap;
            q_cause   <= n_cause;
        end else if (!fw_stall_mem) begin
            q_valid <= 1'b0;
            q_trap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_boa_stage_mem.sv
// Directed self-checking bench for boa_stage_mem.
// Timeout steps run only when BOA_MEM_TIMEOUT_EN is defined.
module tb_boa_stage_mem;
    import boa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        d_valid;
    logic [31:1] d_pc;
    logic [31:0] d_insn;
    logic        d_use_rd;
    logic [31:0] d_rs1_val;
    logic [31:0] d_rs2_val;
    logic        d_trap;
    logic [3:0]  d_cause;
    logic        q_valid;
    logic [31:1] q_pc;
    logic [31:0] q_insn;
    logic        q_use_rd;
    logic [31:0] q_rs1_val;
    logic        q_trap;
    logic [3:0]  q_cause;
    logic        bus_re;
    logic [3:0]  bus_we;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        fw_stall_mem;
    logic        fw_stall_req;
    logic        fw_rd;
    logic [31:0] fw_out;

    int n_run  = 0;
    int n_fail = 0;

    boa_stage_mem #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .d_valid      (d_valid),
        .d_pc         (d_pc),
        .d_insn       (d_insn),
        .d_use_rd     (d_use_rd),
        .d_rs1_val    (d_rs1_val),
        .d_rs2_val    (d_rs2_val),
        .d_trap       (d_trap),
        .d_cause      (d_cause),
        .q_valid      (q_valid),
        .q_pc         (q_pc),
        .q_insn       (q_insn),
        .q_use_rd     (q_use_rd),
        .q_rs1_val    (q_rs1_val),
        .q_trap       (q_trap),
        .q_cause      (q_cause),
        .bus_re       (bus_re),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata),
        .fw_stall_mem (fw_stall_mem),
        .fw_stall_req (fw_stall_req),
        .fw_rd        (fw_rd),
        .fw_out       (fw_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ld_i(input logic [2:0] f3);
        return {17'd0, f3, 5'd5, OP_LOAD};
    endfunction

    function automatic logic [31:0] st_i(input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd0, OP_STORE};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] insn, input logic [31:0] a,
                         input logic [31:0] s);
        d_valid   = 1'b1;
        d_pc      = d_pc + 31'd2;
        d_insn    = insn;
        d_use_rd  = insn[6:0] != OP_STORE;
        d_rs1_val = a;
        d_rs2_val = s;
        d_trap    = 1'b0;
        d_cause   = 4'd0;
    endtask

    task automatic idle();
        d_valid   = 1'b0;
        d_insn    = 32'd0;
        d_use_rd  = 1'b0;
        d_trap    = 1'b0;
        bus_ready = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        clear        = 1'b0;
        fw_stall_mem = 1'b0;
        bus_ready    = 1'b0;
        bus_rdata    = 32'd0;
        d_pc         = 31'h7FF;
        drive(ld_i(F3_W), 32'h1000, 32'd0);
        #1;
        chk("rst_bus_re", bus_re, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_stall", fw_stall_req, 0);
        @(posedge clk) #1;
        chk("rst_q", {q_valid, q_trap, q_cause}, 0);
        chk("rst_q_val", q_rs1_val, 0);

        // LW with same-cycle ready
        @(negedge clk);
        rst = 1'b1;
        drive(ld_i(F3_W), 32'h1000, 32'd0);
        bus_ready = 1'b1;
        bus_rdata = 32'hDEADBEEF;
        #1;
        chk("lw_req", {bus_re, fw_stall_req, bus_addr}, {2'b10, 30'h400});
        chk("lw_fw", {31'd0, fw_rd}, 1);
        chk("lw_fw_out", fw_out, 32'hDEADBEEF);
        @(posedge clk) #1;
        chk("lw_q", q_rs1_val, 32'hDEADBEEF);
        chk("lw_qv", {q_valid, q_trap}, 2'b10);
        chk("lw_pc", q_pc, d_pc);
        @(negedge clk);
        idle();
        #1;
        chk("lw_drop_re", bus_re, 0);

        // LB at 0x1003, ready after three wait cycles
        @(negedge clk);
        drive(ld_i(F3_B), 32'h1003, 32'd0);
        bus_rdata = 32'h80112233;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lb_wait", {fw_stall_req, bus_re, bus_addr},
                {2'b11, 30'h400});
            @(posedge clk) #1;
            chk("lb_bubble", q_valid, 0);
            @(negedge clk);
        end
        bus_ready = 1'b1;
        #1;
        chk("lb_done", {fw_stall_req, fw_rd}, 2'b01);
        chk("lb_fw_out", fw_out, 32'hFFFFFF80);
        @(posedge clk) #1;
        chk("lb_q", q_rs1_val, 32'hFFFFFF80);

        @(negedge clk);
        drive(ld_i(F3_BU), 32'h1003, 32'd0);
        @(posedge clk) #1;
        chk("lbu_q", q_rs1_val, 32'h00000080);

        // Stores
        @(negedge clk);
        drive(st_i(F3_H), 32'h2002, 32'h0000ABCD);
        #1;
        chk("sh_we", {bus_re, bus_we}, 5'b01100);
        chk("sh_wdata", bus_wdata, 32'hABCDABCD);
        chk("sh_addr", bus_addr, 30'h800);
        chk("sh_fw", fw_rd, 0);
        @(posedge clk) #1;
        chk("sh_q", q_rs1_val, 32'h2002);

        @(negedge clk);
        drive(st_i(F3_B), 32'h2001, 32'h12345678);
        #1;
        chk("sb_we", bus_we, 4'b0010);
        chk("sb_wdata", bus_wdata, 32'h78787878);

        // Misaligned and illegal accesses
        @(negedge clk);
        drive(ld_i(F3_W), 32'h1001, 32'd0);
        #1;
        chk("lw_mis_re", bus_re, 0);
        @(posedge clk) #1;
        chk("lw_mis_q", {q_valid, q_trap, q_cause}, {2'b11, 4'd4});

        @(negedge clk);
        drive(st_i(F3_W), 32'h1002, 32'd0);
        #1;
        chk("sw_mis_we", bus_we, 0);
        @(posedge clk) #1;
        chk("sw_mis_q", {q_trap, q_cause}, {1'b1, 4'd6});

        @(negedge clk);
        drive(ld_i(3'b011), 32'h1000, 32'd0);
        #1;
        chk("ill_re", bus_re, 0);
        @(posedge clk) #1;
        chk("ill_q", {q_trap, q_cause}, {1'b1, 4'd2});

        @(negedge clk);
        drive(ld_i(F3_W), 32'h55, 32'd0);
        d_trap  = 1'b1;
        d_cause = 4'hB;
        #1;
        chk("trap_re", bus_re, 0);
        @(posedge clk) #1;
        chk("trap_q", {q_trap, q_cause}, {1'b1, 4'hB});
        chk("trap_val", q_rs1_val, 32'h55);

        // Non-memory pass-through, then clear
        @(negedge clk);
        drive({17'd0, 3'd0, 5'd10, 7'b0110011}, 32'h12345678, 32'd0);
        bus_ready = 1'b0;
        #1;
        chk("alu_fw", {fw_rd, bus_re, bus_we}, 6'b100000);
        chk("alu_fw_out", fw_out, 32'h12345678);
        @(posedge clk) #1;
        chk("alu_q", {q_valid, q_trap}, 2'b10);
        chk("alu_val", q_rs1_val, 32'h12345678);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk) #1;
        chk("clr_q", {q_valid, q_trap}, 0);

        // Completion while WB is stalled
        @(negedge clk);
        clear = 1'b0;
        drive(ld_i(F3_W), 32'h1004, 32'd0);
        fw_stall_mem = 1'b1;
        bus_ready    = 1'b1;
        bus_rdata    = 32'hCAFEF00D;
        @(posedge clk) #1;
        chk("held_q", q_rs1_val, 32'h12345678);
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        chk("held_nore", {bus_re, fw_rd}, 2'b01);
        chk("held_fw", fw_out, 32'hCAFEF00D);
        @(negedge clk);
        fw_stall_mem = 1'b0;
        #1;
        chk("rel_nore", bus_re, 0);
        @(posedge clk) #1;
        chk("rel_q", q_rs1_val, 32'hCAFEF00D);
        chk("rel_qv", q_valid, 1);

        // Clear while the bus is still busy
        @(negedge clk);
        drive(ld_i(F3_W), 32'h1008, 32'd0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        bus_ready = 1'b1;
        bus_rdata = 32'h11111111;
        #1;
        chk("clrw_req", {bus_re, fw_rd, bus_addr}, {2'b10, 30'h402});
        @(posedge clk) #1;
        chk("clrw_q", {31'd0, q_valid}, 0);
        chk("clrw_val", q_rs1_val, 32'hCAFEF00D);
        @(negedge clk);
        idle();
        #1;
        chk("clrw_re", bus_re, 0);

        // Asynchronous reset mid-wait
        @(negedge clk);
        drive(ld_i(F3_W), 32'h100C, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_bus", {bus_re, bus_we, q_valid}, 0);
        chk("arst_q", q_rs1_val, 0);
        chk("arst_insn", q_insn, 0);
        @(negedge clk);
        rst = 1'b1;
        idle();

`ifdef BOA_MEM_TIMEOUT_EN
        @(negedge clk);
        drive(ld_i(F3_W), 32'h1010, 32'd0);
        #1;
        chk("to_re", bus_re, 1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            #1;
            chk("to_stall", {bus_re, fw_stall_req}, {1'b1, i < 4});
        end
        @(posedge clk) #1;
        chk("to_q", {q_valid, q_trap, q_cause}, {2'b11, 4'd5});
        @(negedge clk);
        idle();
        #1;
        chk("to_re_drop", bus_re, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/boa_stage_mem.md
Name: boa_stage_mem

Overview:
- Boa³² MEM pipeline stage, directly downstream of the EX stage. Consumes the EX/MEM register: the address/ALU result and the store data.
- Performs LOAD/STORE over a ready-handshaked data bus: byte-lane steering, sign/zero extension, misalignment traps.
- Passes non-memory instructions through to the MEM/WB register and produces the MEM forwarding value.

Parameters:
- TIMEOUT_CYCLES, 64, bus wait cycles before access fault; used only with BOA_MEM_TIMEOUT_EN.

Ports:
- clk  in  1  CPU clock
- rst  in  1  asynchronous active-low reset
- clear  in  1  invalidate results, clear traps
- d_valid, d_pc[31:1], d_insn[31:0], d_use_rd, d_rs1_val[31:0] (address/result), d_rs2_val[31:0] (store data), d_trap, d_cause[3:0]  in  EX/MEM register
- q_valid, q_pc[31:1], q_insn[31:0], q_use_rd, q_rs1_val[31:0] (final result), q_trap, q_cause[3:0]  out  MEM/WB register
- bus_re  out  1  read request
- bus_we  out  4  byte write enables
- bus_addr  out  30  word address [31:2]
- bus_wdata  out  32  lane-replicated store data
- bus_ready  in  1  access complete this cycle
- bus_rdata  in  32  read word, valid with bus_ready
- fw_stall_mem  in  1  hold MEM/WB register
- fw_stall_req  out  1  MEM needs more cycles (bus pending)
- fw_rd  out  1  fw_out is a final RD value
- fw_out  out  32  forwarding value

Behaviour:
- Reset (rst low, async): every q_* = 0; FSM = S_IDLE; bus_re = 0; bus_we = 0; timeout counter = 0.
- mem_op = d_valid && !d_trap && opcode in {LOAD, STORE}.
- misaligned = (half && addr[0]) || (word && addr[1:0] != 0).
- A misaligned mem_op issues no bus request. It sets q_trap with cause 4 (load) or 6 (store).
- Incoming d_trap passes through unchanged.
- FSM states:
  - S_IDLE: if mem_op && !misaligned, drive the request combinationally from d_*.
    - bus_ready && !fw_stall_mem: latch the result; stay in S_IDLE. Load latency is 1 cycle.
    - bus_ready && fw_stall_mem: capture the formatted rdata into a hold register; go to S_HELD.
    - !bus_ready: go to S_WAIT.
  - S_WAIT: hold the request stable; fw_stall_req = 1.
    - On bus_ready: go to S_IDLE, or to S_HELD if fw_stall_mem.
  - S_HELD: no bus request. When !fw_stall_mem, load the hold register into q_rs1_val and go to S_IDLE.
- Handshake: bus_re/bus_we, bus_addr and bus_wdata stay constant from first assertion until the bus_ready cycle. They are deasserted the cycle after.
- fw_stall_req = (request active && !bus_ready).
- Stores:
  - SB: bus_we = 4'b0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: bus_we = 4'b0011 << addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: bus_we = 4'b1111.
- Loads: extract a byte or halfword at lane addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend. Any other funct3 → illegal instruction trap, cause 2, no access.
- Non-mem instructions: q_rs1_val = d_rs1_val; no bus activity.
- fw_rd / fw_out:
  - Non-mem instruction: fw_rd = d_valid && d_use_rd; fw_out = d_rs1_val.
  - Load: fw_rd = 1 only in the bus_ready cycle or in S_HELD; fw_out = formatted data.
  - Stores: fw_rd = 0.
- MEM/WB register, when !fw_stall_mem and no request pending: q_* ← d_* plus the result.
  - While fw_stall_req = 1, q_valid ← 0 (bubble into WB).
  - While fw_stall_mem = 1, the register is held.
- clear:
  - q_valid ← 0 and q_trap ← 0 next edge.
  - An outstanding request in S_WAIT is not retracted; it completes, and its data is discarded.
  - S_HELD returns to S_IDLE.
- Simultaneous clear and bus_ready: the access completes and the result is dropped.
- Reset mid-access: bus request drops immediately (async).

Optional Feature:
- BOA_MEM_TIMEOUT_EN defined:
  - An 8+-bit counter increments each S_WAIT cycle.
  - When it reaches TIMEOUT_CYCLES: abandon the request, go to S_IDLE, raise q_trap with cause 5 (load) or 7 (store). Counter clears on any bus_ready.
- Undefined: no counter; S_WAIT waits indefinitely.

Decomposition:
- Shared package boa_pkg:
  - FSM enum (S_IDLE, S_WAIT, S_HELD).
  - Trap cause constants (2, 4, 5, 6, 7).
  - Load/store funct3 constants.
- Sub-module boa_mem_align: purely combinational lane steering/extension: funct3, addr[1:0], rs2, rdata → bus_we, wdata, load result, misaligned.

Test Plan:
- LW at 0x1000, bus_ready same cycle, rdata 0xDEADBEEF → q_rs1_val 0xDEADBEEF next edge; fw_rd=1 in that cycle; fw_stall_req=0.
- LB at 0x1003, rdata 0x80112233, ready after 3 cycles → fw_stall_req high 3 cycles, request stable, q_rs1_val 0xFFFFFF80; LBU same → 0x00000080.
- SH to 0x2002, rs2 0x0000ABCD → bus_we 4'b1100, bus_wdata 0xABCDABCD, bus_addr 0x800.
- LW at 0x1001 → no bus_re, q_trap=1, q_cause=4; SW at 0x1002 → q_cause=6.
- Load completes while fw_stall_mem high 2 cycles → S_HELD, no second bus request, q_rs1_val updated on release; clear asserted in S_WAIT → access finishes, q_valid=0.
- With BOA_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, bus_ready never high on load → request drops after 4 wait cycles, q_trap=1, q_cause=5; async rst low mid-wait → all q_* 0, bus_re 0 immediately.
